// File: rtl/cmd_reader_mc.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_reader_mc
//  Description : In-band command reader. Pops timestamped command packets
//                from a show-ahead TX FIFO, holds each packet until adc_time
//                enters its execution window, then executes PING, WRITE,
//                MASKED (read-modify-write), READ and DELAY commands. Replies
//                (including NACKs for unknown/truncated commands) are sent as
//                16-bit halves on the RX path.
//  Ports       : txclk/reset_n     - clock, async active-low reset
//                adc_time          - free-running timestamp
//                pkt_waiting/fifodata/rdreq/skip - FIFO side
//                rx_WR_enabled/rx_databus/rx_WR/rx_WR_done - reply side
//                reg_addr/reg_data_in/reg_wr/reg_rd/reg_data_out - reg bus
//                stop/stop_time    - per-channel delay pulse and value
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_reader_mc #(
  parameter int JITTER   = 5,
  parameter int REG_AW   = 7,
  parameter int NUM_CHAN = 2
) (
  input  logic                txclk,
  input  logic                reset_n,
  input  logic [31:0]         adc_time,
  input  logic                pkt_waiting,
  input  logic [31:0]         fifodata,
  output logic                rdreq,
  output logic                skip,
  input  logic                rx_WR_enabled,
  output logic [15:0]         rx_databus,
  output logic                rx_WR,
  output logic                rx_WR_done,
  output logic [REG_AW-1:0]   reg_addr,
  output logic [31:0]         reg_data_in,
  output logic                reg_wr,
  output logic                reg_rd,
  input  logic [31:0]         reg_data_out,
  output logic [NUM_CHAN-1:0] stop,
  output logic [15:0]         stop_time
);

  localparam logic [7:0]  c_op_ping   = 8'h00;
  localparam logic [7:0]  c_op_write  = 8'h02;
  localparam logic [7:0]  c_op_masked = 8'h03;
  localparam logic [7:0]  c_op_read   = 8'h04;
  localparam logic [7:0]  c_op_delay  = 8'h0C;
  localparam logic [7:0]  c_num_chan  = 8'(NUM_CHAN);
  localparam logic [31:0] c_jitter    = 32'(JITTER);
  localparam logic [31:0] c_ts_now    = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HEADER  = 4'd1,
    S_TSTAMP  = 4'd2,
    S_WAIT    = 4'd3,
    S_DECODE  = 4'd4,
    S_FETCH   = 4'd5,
    S_REG_RD  = 4'd6,
    S_REG_CAP = 4'd7,
    S_REG_WR  = 4'd8,
    S_REPLY   = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;          // payload words still in FIFO
  logic [31:0]         ts_q, ts_d;
  logic [7:0]          op_q, op_d;            // op being executed across states
  logic                fetch_idx_q, fetch_idx_d;
  logic [31:0]         val_q, val_d;
  logic [31:0]         mask_q, mask_d;
  logic                trunc_q, trunc_d;      // truncated packet: skip after NACK
  logic [3:0][15:0]    reply_q, reply_d;
  logic [1:0]          reply_idx_q, reply_idx_d;
  logic [1:0]          reply_last_q, reply_last_d;
  logic                done_q, done_d;
  logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
  logic [31:0]         reg_data_in_q, reg_data_in_d;
  logic [NUM_CHAN-1:0] stop_q, stop_d;
  logic [15:0]         stop_time_q, stop_time_d;

  logic [7:0]          w_cmd_op;
  logic [7:0]          w_cmd_arg;
  logic [15:0]         w_cmd_data;
  logic [31:0]         w_delta;
  logic                w_nack;

  assign w_cmd_op   = fifodata[31:24];
  assign w_cmd_arg  = fifodata[23:16];
  assign w_cmd_data = fifodata[15:0];
  // Modular difference: the sign bit tells "in the past" from "in the future"
  // even across a 32-bit wrap of adc_time.
  assign w_delta    = ts_q - adc_time;

  assign rx_WR_done  = done_q;
  assign reg_addr    = reg_addr_q;
  assign reg_data_in = reg_data_in_q;
  assign stop        = stop_q;
  assign stop_time   = stop_time_q;

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ts_q          <= '0;
      op_q          <= '0;
      fetch_idx_q   <= 1'b0;
      val_q         <= '0;
      mask_q        <= '0;
      trunc_q       <= 1'b0;
      reply_q       <= '0;
      reply_idx_q   <= '0;
      reply_last_q  <= '0;
      done_q        <= 1'b0;
      reg_addr_q    <= '0;
      reg_data_in_q <= '0;
      stop_q        <= '0;
      stop_time_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ts_q          <= ts_d;
      op_q          <= op_d;
      fetch_idx_q   <= fetch_idx_d;
      val_q         <= val_d;
      mask_q        <= mask_d;
      trunc_q       <= trunc_d;
      reply_q       <= reply_d;
      reply_idx_q   <= reply_idx_d;
      reply_last_q  <= reply_last_d;
      done_q        <= done_d;
      reg_addr_q    <= reg_addr_d;
      reg_data_in_q <= reg_data_in_d;
      stop_q        <= stop_d;
      stop_time_q   <= stop_time_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ts_d          = ts_q;
    op_d          = op_q;
    fetch_idx_d   = fetch_idx_q;
    val_d         = val_q;
    mask_d        = mask_q;
    trunc_d       = trunc_q;
    reply_d       = reply_q;
    reply_idx_d   = reply_idx_q;
    reply_last_d  = reply_last_q;
    done_d        = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_data_in_d = reg_data_in_q;
    stop_d        = '0;
    stop_time_d   = stop_time_q;
    w_nack        = 1'b0;
    rdreq         = 1'b0;
    skip          = 1'b0;
    reg_rd        = 1'b0;
    reg_wr        = 1'b0;
    rx_WR         = 1'b0;
    rx_databus    = 16'h0000;

    case (state_q)
      S_IDLE: begin
        trunc_d = 1'b0;
        if (pkt_waiting) begin
          state_d = S_HEADER;
        end
      end

      S_HEADER: begin
        rdreq   = 1'b1;
        cnt_d   = fifodata[8:2];
        state_d = S_TSTAMP;
      end

      S_TSTAMP: begin
        rdreq   = 1'b1;
        ts_d    = fifodata;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if ((ts_q == c_ts_now) ||
            ((w_delta != 32'd0) && (w_delta <= c_jitter))) begin
          state_d = S_DECODE;
        end else if ((w_delta == 32'd0) || w_delta[31]) begin
          skip    = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_DECODE: begin
        // The skip is taken here rather than alongside the last pop so
        // that skip and rdreq are never asserted together.
        if ((cnt_q == 7'd0) || trunc_q) begin
          skip    = 1'b1;
          state_d = S_IDLE;
        end else begin
          rdreq       = 1'b1;
          cnt_d       = cnt_q - 7'd1;
          op_d        = w_cmd_op;
          fetch_idx_d = 1'b0;
          reply_idx_d = 2'd0;
          case (w_cmd_op)
            c_op_ping: begin
              reply_d[0]   = 16'h0102;
              reply_d[1]   = w_cmd_data;
              reply_last_d = 2'd1;
              state_d      = S_REPLY;
            end
            c_op_write: begin
              // cnt_q still counts the command word itself.
              if (cnt_q < 7'd2) begin
                w_nack  = 1'b1;
                trunc_d = 1'b1;
              end else begin
                reg_addr_d = w_cmd_data[REG_AW-1:0];
                state_d    = S_FETCH;
              end
            end
            c_op_masked: begin
              if (cnt_q < 7'd3) begin
                w_nack  = 1'b1;
                trunc_d = 1'b1;
              end else begin
                reg_addr_d = w_cmd_data[REG_AW-1:0];
                state_d    = S_FETCH;
              end
            end
            c_op_read: begin
              reg_addr_d   = w_cmd_data[REG_AW-1:0];
              reply_d[0]   = 16'h0506;
              reply_d[1]   = w_cmd_data;
              reply_last_d = 2'd3;
              state_d      = S_REG_RD;
            end
            c_op_delay: begin
              if (w_cmd_arg < c_num_chan) begin
                for (int i = 0; i < NUM_CHAN; i++) begin
                  if (w_cmd_arg == 8'(i)) begin
                    stop_d[i] = 1'b1;
                  end
                end
                stop_time_d = w_cmd_data;
              end else begin
                w_nack = 1'b1;
              end
            end
            default: begin
              w_nack = 1'b1;
            end
          endcase
          if (w_nack) begin
            reply_d[0]   = {8'h0F, w_cmd_op};
            reply_d[1]   = {w_cmd_arg, 8'h00};
            reply_last_d = 2'd1;
            state_d      = S_REPLY;
          end
        end
      end

      S_FETCH: begin
        rdreq = 1'b1;
        cnt_d = cnt_q - 7'd1;
        if (!fetch_idx_q) begin
          val_d = fifodata;
          if (op_q == c_op_write) begin
            reg_data_in_d = fifodata;
            state_d       = S_REG_WR;
          end else begin
            fetch_idx_d = 1'b1;
          end
        end else begin
          mask_d  = fifodata;
          state_d = S_REG_RD;
        end
      end

      S_REG_RD: begin
        reg_rd  = 1'b1;
        state_d = S_REG_CAP;
      end

      S_REG_CAP: begin
        if (op_q == c_op_masked) begin
          reg_data_in_d = (reg_data_out & ~mask_q) | (val_q & mask_q);
          state_d       = S_REG_WR;
        end else begin
          reply_d[2] = reg_data_out[15:0];
          reply_d[3] = reg_data_out[31:16];
          state_d    = S_REPLY;
        end
      end

      S_REG_WR: begin
        reg_wr  = 1'b1;
        state_d = S_DECODE;
      end

      S_REPLY: begin
        rx_databus = reply_q[reply_idx_q];
        if (rx_WR_enabled) begin
          rx_WR = 1'b1;
          if (reply_idx_q == reply_last_q) begin
            done_d  = 1'b1;
            state_d = S_DECODE;
          end else begin
            reply_idx_d = reply_idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
